seq_detect_mealy: RTL and testbench
===================================

# seq_detect_mealy

Parametrised Mealy-style serial pattern detector: the generalised successor of the single-pattern FSM exercised in HW5 Q1. It watches a 1-bit serial input and flags every occurrence of a configurable N-bit pattern, with selectable overlapping or non-overlapping detection. It also provides an enable, a registered match strobe and a saturating match counter. It sits directly on a serial data line and feeds downstream control logic or a testbench scoreboard.

## Interface
- N, 4: pattern length in bits, 2..16
- PATTERN, 4'b1011: pattern, MSB received first
- OVERLAP, 1: 1 = overlapping matches allowed, 0 = restart after each match
- CNT_W, 8: match counter width

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  sample enable; w is ignored and state holds when low
- w  input  1  serial data bit
- clear  input  1  synchronous clear of count only
- out  output  1  Mealy match flag, combinational from state, w and en
- match_q  output  1  out registered; one-cycle pulse per match
- count  output  CNT_W  saturating number of matches since reset/clear

## Operation
- State k in 0..N-1 is the number of pattern bits matched so far (the longest pattern prefix equal to a suffix of the input).
- Expected bit in state k is PATTERN[N-1-k].
- On a clk edge with en=1:
  - w equals the expected bit and k<N-1: k <= k+1.
  - w equals the expected bit and k=N-1: this is a match. With OVERLAP=1, k <= F, where F is the length of the longest proper prefix of PATTERN that is also its suffix. With OVERLAP=0, k <= 0.
  - Mismatch: k <= the longest prefix of PATTERN that is a suffix of (matched prefix followed by w). This is the KMP fallback, computed at elaboration.
- On a clk edge with en=0: k holds.
- out = en & ~reset & (k==N-1) & (w==PATTERN[0]).
- On a clk edge where out=1:
  - match_q <= 1.
  - count <= count+1, saturating at 2^CNT_W-1.
- clear=1 sets count <= 0. If clear and a match occur in the same cycle, count <= 1.
- While reset is asserted: k=0, match_q=0, count=0 and out=0, regardless of en or w.

## Timing
- Reset values: out=0, match_q=0, count=0, state=0.
- out is asserted in the same cycle the final pattern bit is presented, ahead of the sampling edge.
- match_q and count update at that same edge, so they are visible one cycle after out.
- Back-to-back matches are possible only with OVERLAP=1 and F=N-1 (e.g. PATTERN all ones). In that case out and match_q stay high on consecutive cycles, and count increments each cycle.
- Reset asserted mid-pattern discards partial progress immediately (asynchronous). The first edge after deassertion starts from state 0.
- No combinational path from clear to any output.

## Structure
- Shared include seq_defs.vh holds:
  - the elaboration-time function next_state(k, w, PATTERN, N) that computes the KMP fallback table;
  - the overlap-length function F;
  - the state-width localparam $clog2(N).
- Sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc, clear; output count) implements the saturating counter with clear priority rules. It is reused by other HW blocks.
- Top level holds the state register, the fallback lookup, out, and match_q.

## Test plan
- N=4, PATTERN=1011, OVERLAP=1, en=1; stream 1,0,1,1,0,1,1 -> out high during bits 4 and 7; match_q pulses one cycle after each; count=2.
- Same stream with OVERLAP=0 -> out high only during bit 4; count=1. The state after bit 7 is 1.
- Stream 1,0,1 then en=0 for 3 cycles with w toggling, then en=1 and w=1 -> state holds at 3. out is high on the final bit only; count=1.
- Stream 1,0,1, assert reset asynchronously mid-cycle, release, then w=1 -> no match. out, match_q and count all remain 0 from the reset assertion onward.
- CNT_W=2, PATTERN=11, OVERLAP=1, w=1 for 8 cycles -> out high from cycle 2 onward, and count saturates at 3.
- clear asserted in the same cycle as a match with count=2 -> count=1 next cycle. clear alone -> count=0 without affecting state.

Source files
------------

// File: rtl/seq_detect_mealy_pkg.sv
// Shared elaboration-time helpers for the serial pattern detector family.
// No logic of its own: constant functions only, evaluated while building tables.
// Patterns are passed zero-extended to 16 bits, MSB of the N-bit field received first.
package seq_detect_mealy_pkg;

    localparam int MAX_N = 16;

    // Width of the "bits matched so far" state for an n-bit pattern.
    function automatic int state_w(input int n);
        return $clog2(n);
    endfunction

    // Longest proper prefix of the pattern that is a suffix of
    // (first k pattern bits followed by w). Capping at n-1 makes the
    // full-match case return the overlap length directly.
    function automatic int next_state(input int k, input logic w,
                                      input logic [MAX_N-1:0] pat, input int n);
        int   res;
        bit   found;
        bit   ok;
        int   j;
        logic sb;
        res   = 0;
        found = 1'b0;
        for (int l = n - 1; l >= 1; l--) begin
            if (!found && (l <= k + 1)) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    j  = k + 1 - l + i;
                    sb = (j < k) ? pat[n-1-j] : w;
                    if (pat[n-1-i] != sb) ok = 1'b0;
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Length of the longest proper prefix that is also a suffix (restart
    // point after an overlapping match).
    function automatic int overlap_len(input logic [MAX_N-1:0] pat, input int n);
        return next_state(n - 1, pat[0], pat, n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear+inc together loads 1.
// Latency: count reflects inc/clear one cycle after the sampling edge.
// No backpressure: inc is accepted every cycle, extra events at the ceiling are dropped.
//   clk, reset (async, active-high), inc, clear -> count[CNT_W-1:0]
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            // The event coinciding with the clear is the first of the new epoch.
            count <= inc ? CNT_ONE : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// Mealy serial pattern detector with KMP fallback, registered strobe and match counter.
// Latency: out is combinational in the final-bit cycle; match_q/count follow one cycle later.
// No backpressure: en=0 freezes state and ignores w; every enabled cycle is consumed.
//   clk, reset (async, active-high), en, w, clear -> out, match_q, count[CNT_W-1:0]
module seq_detect_mealy
    import seq_detect_mealy_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic             clear,
    output logic             out,
    output logic             match_q,
    output logic [CNT_W-1:0] count
);

    localparam int               SW     = state_w(N);
    localparam logic [MAX_N-1:0] PAT16  = MAX_N'(PATTERN);
    localparam logic [SW-1:0]    F_S    = SW'(overlap_len(PAT16, N));
    localparam logic [SW-1:0]    LAST_S = SW'(N - 1);

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;

    // Per-state lookup tables, all constants resolved at elaboration.
    logic [SW-1:0] tab0    [N];
    logic [SW-1:0] tab1    [N];
    logic          exp_tab [N];

    for (genvar k = 0; k < N; k++) begin : g_tab
        localparam logic [SW-1:0] NXT0 = SW'(next_state(k, 1'b0, PAT16, N));
        localparam logic [SW-1:0] NXT1 = SW'(next_state(k, 1'b1, PAT16, N));
        assign tab0[k]    = NXT0;
        assign tab1[k]    = NXT1;
        assign exp_tab[k] = PATTERN[N-1-k];
    end

    logic at_last;
    logic hit;

    assign at_last = (state == LAST_S);
    assign hit     = (w == exp_tab[state]);
    assign out     = en & ~reset & at_last & (w == PATTERN[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= '0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            if (at_last && hit) begin
                state_nxt = OVERLAP ? F_S : '0;
            end else begin
                // Covers both advance (k+1) and mismatch fallback.
                state_nxt = w ? tab1[state] : tab0[state];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_q <= 1'b0;
        else       match_q <= out;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out),
        .clear (clear),
        .count (count)
    );

endmodule

// File: tb/tb_seq_detect_mealy.sv
module tb_seq_detect_mealy;

    logic clk = 1'b0;
    logic reset, en, w, clear;

    logic       out0, out1, out2, out3;
    logic       mq0, mq1, mq2, mq3;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [3:0] c3;

    always #5 clk = ~clk;

    seq_detect_mealy #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .out(out0), .match_q(mq0), .count(c0));
    seq_detect_mealy #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .out(out1), .match_q(mq1), .count(c1));
    seq_detect_mealy #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .out(out2), .match_q(mq2), .count(c2));
    seq_detect_mealy #(.N(5), .PATTERN(5'b10100), .OVERLAP(1'b1), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .out(out3), .match_q(mq3), .count(c3));

    // Configuration of each instance, as seen by the reference model.
    int          n_a   [4] = '{4, 4, 2, 5};
    logic [15:0] pat_a [4] = '{16'h000b, 16'h000b, 16'h0003, 16'h0014};
    bit          ov_a  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          max_a [4] = '{255, 255, 3, 15};

    logic out_v [4];
    logic mq_v  [4];
    int   cnt_v [4];

    always_comb begin
        out_v[0] = out0; out_v[1] = out1; out_v[2] = out2; out_v[3] = out3;
        mq_v[0]  = mq0;  mq_v[1]  = mq1;  mq_v[2]  = mq2;  mq_v[3]  = mq3;
        cnt_v[0] = int'(c0); cnt_v[1] = int'(c1);
        cnt_v[2] = int'(c2); cnt_v[3] = int'(c3);
    end

    // Reference model: history of accepted bits since the last restart
    // (reset, or a match when overlap is off); a match is simply "the last
    // N bits of that history equal the pattern".
    logic [15:0] hist  [4];
    int          len   [4];
    int          m_cnt [4];
    logic        m_mq  [4];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_out(input int i);
        logic [15:0] mask;
        logic [15:0] cand;
        if (!en || reset) return 1'b0;
        if (len[i] < n_a[i] - 1) return 1'b0;
        mask = 16'((32'd1 << n_a[i]) - 32'd1);
        cand = {hist[i][14:0], w} & mask;
        return (cand == pat_a[i]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hist[i]  = '0;
            len[i]   = 0;
            m_cnt[i] = 0;
            m_mq[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic o;
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                o = exp_out(i);
                m_mq[i] = o;
                if (clear)                        m_cnt[i] = o ? 1 : 0;
                else if (o && m_cnt[i] < max_a[i]) m_cnt[i]++;
                if (en) begin
                    if (o && !ov_a[i]) begin
                        len[i] = 0;
                    end else begin
                        hist[i] = {hist[i][14:0], w};
                        len[i]  = (len[i] < 16) ? len[i] + 1 : 16;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out%0d", i),     int'(out_v[i]), int'(exp_out(i)));
            chk($sformatf("match_q%0d", i), int'(mq_v[i]),  int'(m_mq[i]));
            chk($sformatf("count%0d", i),   cnt_v[i],       m_cnt[i]);
        end
    endtask

    // One clock: model absorbs the edge, then new inputs are applied
    // (reset changes mid-cycle, i.e. asynchronously) and outputs checked.
    task automatic cycle(input logic en_i, input logic w_i,
                         input logic clr_i, input logic rst_i);
        @(posedge clk);
        model_edge();
        #1;
        en    = en_i;
        w     = w_i;
        clear = clr_i;
        reset = rst_i;
        if (rst_i) model_clear();
        #2;
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [6:0] s1;
    initial begin
        s1 = 7'b1011011;
        reset = 1'b1; en = 1'b0; w = 1'b0; clear = 1'b0;
        model_clear();
        #2;
        check_all();
        do_reset();

        // 1011011: overlap sees two matches, non-overlap one.
        for (int b = 6; b >= 0; b--) cycle(1'b1, s1[b], 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_cnt_ovl", cnt_v[0], 2);
        chk("tp_cnt_novl", cnt_v[1], 1);
        chk("tp_cnt_11", cnt_v[2], 2);

        // Continue with 0,1,1: match on the last bit together with clear.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_match", cnt_v[0], 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_only", cnt_v[0], 0);

        // Enable hold: 1,0,1 then en low with w toggling, then final 1.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, i[0], 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("hold_out", int'(out0), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_cnt", cnt_v[0], 1);

        // Async reset mid-pattern discards progress.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_out", int'(out0), 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_out_after", int'(out0), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_cnt", cnt_v[0], 0);

        // All-ones stream on the 2-bit pattern: back-to-back and saturation.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("b2b_out", int'(out2), 1);
        chk("b2b_mq", int'(mq2), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", cnt_v[2], 3);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) != 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
